button_tx_ctrl: RTL and testbench

- Sequences the output of the button debouncer into byte messages for the UART transmitter.
- Detects press and release edges on the debounced button and emits PRESS_CODE or RELEASE_CODE.
- While the button is held, emits REPEAT_CODE at a fixed rate after an initial hold delay.
- Presents bytes to the UART TX through a one-entry valid/ready output register and keeps a wrapping press counter.

---
 rtl/uart_pkg.sv | 18 +
 rtl/tx_hold_reg.sv | 38 +++
 rtl/button_tx_ctrl.sv | 117 +++++++++++
 tb/tb_button_tx_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and default byte codes for the button-to-UART message path.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT
    } btn_state_t;

    localparam logic [7:0] PRESS_CODE_DEF   = 8'h50;
    localparam logic [7:0] RELEASE_CODE_DEF = 8'h52;
    localparam logic [7:0] REPEAT_CODE_DEF  = 8'h2B;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tx_hold_reg.sv
// One-entry valid/ready output register; a load is taken when empty or on a handshake cycle.
// A load offered while full and stalled is dropped and flagged by a one-cycle overrun pulse.
module tx_hold_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_vld,
    input  logic [W-1:0] load_dat,
    output logic         load_ok,
    output logic [W-1:0] out_dat,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic         overrun
);

    logic xfer;

    assign xfer    = out_vld & out_rdy;
    assign load_ok = load_vld & (~out_vld | out_rdy);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_dat <= '0;
            out_vld <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= load_vld & out_vld & ~out_rdy;
            if (load_ok) begin
                out_dat <= load_dat;
                out_vld <= 1'b1;
            end else if (xfer) begin
                out_vld <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/button_tx_ctrl.sv
// Turns debounced button edges and hold time into PRESS/RELEASE/REPEAT bytes for the UART TX.
// Events reach tx_valid at the edge that first samples the new button level.
module button_tx_ctrl
    import uart_pkg::*;
#(
    parameter int          HOLD_CYCLES   = 100,
    parameter int          REPEAT_CYCLES = 20,
    parameter logic [7:0]  PRESS_CODE    = PRESS_CODE_DEF,
    parameter logic [7:0]  RELEASE_CODE  = RELEASE_CODE_DEF,
    parameter logic [7:0]  REPEAT_CODE   = REPEAT_CODE_DEF
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       en,
    input  logic       button_in,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       overrun,
    output logic [7:0] press_count
);

    localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, REPEAT_CYCLES));
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    logic             btn_q;
    logic             btn_press;
    logic             btn_release;
    btn_state_t       state;
    btn_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             evt_vld;
    logic [7:0]       evt_dat;
    logic             evt_press;
    logic             load_ok;

    // Button is active low: a press is a 1->0 transition.
    assign btn_press   = btn_q & ~button_in;
    assign btn_release = ~btn_q & button_in;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        evt_vld   = 1'b0;
        evt_dat   = 8'h00;
        evt_press = 1'b0;
        if (!en) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (btn_press) begin
                        evt_vld   = 1'b1;
                        evt_dat   = PRESS_CODE;
                        evt_press = 1'b1;
                        state_nxt = HOLD;
                        cnt_nxt   = '0;
                    end
                end
                HOLD, REPEAT: begin
                    // Release wins over a repeat falling due in the same cycle.
                    if (btn_release) begin
                        evt_vld   = 1'b1;
                        evt_dat   = RELEASE_CODE;
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else if (cnt == ((state == HOLD) ? HOLD_LAST : REPEAT_LAST)) begin
                        evt_vld   = 1'b1;
                        evt_dat   = REPEAT_CODE;
                        state_nxt = REPEAT;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            btn_q       <= 1'b1;
            state       <= IDLE;
            cnt         <= '0;
            press_count <= 8'h00;
        end else begin
            btn_q <= button_in;
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (evt_press && load_ok) begin
                press_count <= press_count + 8'd1;
            end
        end
    end

    tx_hold_reg #(
        .W(8)
    ) u_hold (
        .clk     (clk),
        .rst     (RST),
        .load_vld(evt_vld),
        .load_dat(evt_dat),
        .load_ok (load_ok),
        .out_dat (tx_data),
        .out_vld (tx_valid),
        .out_rdy (tx_ready),
        .overrun (overrun)
    );

endmodule

// File: tb/tb_button_tx_ctrl.sv
// Bench for button_tx_ctrl: elapsed-time reference model checked every cycle, plus directed scenarios.
module tb_button_tx_ctrl;

    localparam int HOLD = 10;
    localparam int REP  = 4;

    logic       clk = 1'b0;
    logic       RST;
    logic       en;
    logic       button_in;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       overrun;
    logic [7:0] press_count;

    button_tx_ctrl #(
        .HOLD_CYCLES  (HOLD),
        .REPEAT_CYCLES(REP)
    ) dut (
        .clk        (clk),
        .RST        (RST),
        .en         (en),
        .button_in  (button_in),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .overrun    (overrun),
        .press_count(press_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model state: button level, whether a press is being timed, and the output slot.
    bit         m_init = 0;
    int         m_cyc = 0;
    int         m_press_cyc = 0;
    bit         m_active = 0;
    bit         m_btn = 1;
    bit         m_valid = 0;
    bit         m_ovr = 0;
    logic [7:0] m_data = 8'h00;
    logic [7:0] m_cnt = 8'h00;

    logic [7:0] log_q[$];
    int         ovr_seen = 0;
    bit         s_valid = 0;
    logic [7:0] s_data = 8'h00;

    function automatic logic [7:0] log_at(input int i);
        if (i < log_q.size()) return log_q[i];
        return 8'hxx;
    endfunction

    always begin
        bit         r_rst, r_en, r_b, r_rdy, prs, rls, evt;
        logic [7:0] code;
        int         e;
        @(posedge clk);
        r_rst = RST; r_en = en; r_b = button_in; r_rdy = tx_ready;
        if (!r_rst && s_valid && r_rdy) log_q.push_back(s_data);
        m_cyc++;
        if (r_rst) begin
            m_init = 1; m_btn = 1; m_active = 0;
            m_valid = 0; m_data = 8'h00; m_ovr = 0; m_cnt = 8'h00;
        end else begin
            prs  = m_btn & ~r_b;
            rls  = ~m_btn & r_b;
            evt  = 0;
            code = 8'h00;
            if (!r_en) begin
                m_active = 0;
            end else if (m_active && rls) begin
                evt = 1; code = 8'h52; m_active = 0;
            end else if (!m_active && prs) begin
                evt = 1; code = 8'h50; m_active = 1; m_press_cyc = m_cyc;
            end else if (m_active) begin
                e = m_cyc - m_press_cyc;
                if (e == HOLD || (e > HOLD && (e - HOLD) % REP == 0)) begin
                    evt = 1; code = 8'h2B;
                end
            end
            m_btn = r_b;
            m_ovr = 0;
            if (evt && (!m_valid || r_rdy)) begin
                m_data  = code;
                m_valid = 1;
                if (code == 8'h50) m_cnt = m_cnt + 8'd1;
            end else if (evt) begin
                m_ovr = 1;
            end else if (m_valid && r_rdy) begin
                m_valid = 0;
            end
        end
        #1;
        if (m_init) begin
            chk("tx_valid", {31'd0, tx_valid}, {31'd0, m_valid});
            chk("tx_data", {24'd0, tx_data}, {24'd0, m_data});
            chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
            chk("press_count", {24'd0, press_count}, {24'd0, m_cnt});
        end
        s_valid = tx_valid;
        s_data  = tx_data;
        if (overrun === 1'b1) ovr_seen++;
    end

    task automatic cyc_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        RST = 1'b1; en = 1'b1; button_in = 1'b1; tx_ready = 1'b0;
        cyc_n(4);
        chk("rst_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_data", {24'd0, tx_data}, 32'h00);
        chk("rst_count", {24'd0, press_count}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        RST = 1'b0;

        // Press held 20 cycles with a ready sink
        tx_ready = 1'b1;
        cyc_n(3);
        log_q.delete();
        button_in = 1'b0;
        cyc_n(20);
        button_in = 1'b1;
        cyc_n(3);
        chk("hold_nbytes", log_q.size(), 32'd5);
        chk("hold_b0", {24'd0, log_at(0)}, 32'h50);
        chk("hold_b1", {24'd0, log_at(1)}, 32'h2B);
        chk("hold_b2", {24'd0, log_at(2)}, 32'h2B);
        chk("hold_b3", {24'd0, log_at(3)}, 32'h2B);
        chk("hold_b4", {24'd0, log_at(4)}, 32'h52);
        chk("hold_count", {24'd0, press_count}, 32'd1);

        // Stalled sink: release is dropped
        tx_ready = 1'b0;
        ovr_seen = 0;
        button_in = 1'b0;
        cyc_n(3);
        button_in = 1'b1;
        cyc_n(2);
        chk("stall_overruns", ovr_seen, 32'd1);
        chk("stall_data", {24'd0, tx_data}, 32'h50);
        chk("stall_valid", {31'd0, tx_valid}, 32'd1);
        log_q.delete();
        tx_ready = 1'b1;
        cyc_n(2);
        chk("stall_nbytes", log_q.size(), 32'd1);
        chk("stall_b0", {24'd0, log_at(0)}, 32'h50);
        chk("stall_drained", {31'd0, tx_valid}, 32'd0);

        // Enable raised while already held
        log_q.delete();
        en = 1'b0;
        button_in = 1'b0;
        cyc_n(2);
        en = 1'b1;
        cyc_n(30);
        button_in = 1'b1;
        cyc_n(3);
        chk("en_silent", log_q.size(), 32'd0);
        button_in = 1'b0;
        cyc_n(2);
        button_in = 1'b1;
        cyc_n(3);
        chk("en_nbytes", log_q.size(), 32'd2);
        chk("en_b0", {24'd0, log_at(0)}, 32'h50);

        // press_count wrap
        RST = 1'b1;
        cyc_n(2);
        RST = 1'b0;
        cyc_n(2);
        log_q.delete();
        for (int i = 0; i < 256; i++) begin
            button_in = 1'b0;
            cyc_n(2);
            button_in = 1'b1;
            cyc_n(2);
            if (i == 254) chk("wrap_255", {24'd0, press_count}, 32'd255);
        end
        cyc_n(2);
        chk("wrap_count", {24'd0, press_count}, 32'd0);
        chk("wrap_nbytes", log_q.size(), 32'd512);

        // Handshake coincides with a due repeat, then reset mid-transfer
        cyc_n(3);
        log_q.delete();
        ovr_seen = 0;
        button_in = 1'b0;
        tx_ready = 1'b0;
        cyc_n(10);
        tx_ready = 1'b1;
        cyc_n(1);
        tx_ready = 1'b0;
        chk("rep_valid", {31'd0, tx_valid}, 32'd1);
        chk("rep_data", {24'd0, tx_data}, 32'h2B);
        chk("rep_overruns", ovr_seen, 32'd0);
        chk("rep_b0", {24'd0, log_at(0)}, 32'h50);
        RST = 1'b1;
        button_in = 1'b1;
        cyc_n(1);
        chk("rst_mid_valid", {31'd0, tx_valid}, 32'd0);
        RST = 1'b0;
        tx_ready = 1'b1;
        cyc_n(15);
        chk("rst_mid_nbytes", log_q.size(), 32'd1);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            RST      = ($urandom_range(0, 499) == 0);
            en       = ($urandom_range(0, 15) != 0);
            tx_ready = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 24) == 0) button_in = ~button_in;
        end
        RST = 1'b0;
        cyc_n(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
